// File: rtl/decode_pipe.sv
// decode_pipe: RV32I decode stage with an owned register file and a registered
// D/E boundary.
//   clk, rst_n                 clock, asynchronous active-low reset
//   valid_d, instr_d, pc_d     instruction from fetch
//   we_w, rd_w, wd_w           register-file write port from writeback
//   flush_e, hold_e            kill / freeze the E register
//   stall_d                    fetch must hold this cycle (combinational)
//   a0_d                       committed contents of x10 (combinational)
//   *_e                        registered control, operands and indices for E
module decode_pipe #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_d,
  input  logic [31:0]     instr_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic            we_w,
  input  logic [4:0]      rd_w,
  input  logic [XLEN-1:0] wd_w,
  input  logic            flush_e,
  input  logic            hold_e,
  output logic            stall_d,
  output logic [XLEN-1:0] a0_d,
  output logic            valid_e,
  output logic            illegal_e,
  output logic            regwrite_e,
  output logic            memwrite_e,
  output logic            alusrc_e,
  output logic            branch_e,
  output logic            jump_e,
  output logic            jalr_e,
  output logic            auipc_e,
  output logic [1:0]      resultsrc_e,
  output logic [3:0]      aluctrl_e,
  output logic [2:0]      funct3_e,
  output logic [XLEN-1:0] imm_e,
  output logic [XLEN-1:0] rd1_e,
  output logic [XLEN-1:0] rd2_e,
  output logic [XLEN-1:0] pc_e,
  output logic [XLEN-1:0] pcplus4_e,
  output logic [4:0]      rs1_e,
  output logic [4:0]      rs2_e,
  output logic [4:0]      rd_e
);
  localparam int RA = $clog2(NREGS);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2,
                         ALU_SLT = 4'd3, ALU_SLTU = 4'd4, ALU_XOR = 4'd5,
                         ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_OR = 4'd8,
                         ALU_AND = 4'd9, ALU_PASSB = 4'd10;

  typedef struct packed {
    logic            valid;
    logic            illegal;
    logic            regwrite;
    logic            memwrite;
    logic            alusrc;
    logic            branch;
    logic            jump;
    logic            jalr;
    logic            auipc;
    logic [1:0]      resultsrc;
    logic [3:0]      aluctrl;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcplus4;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } e_bundle_t;

  function automatic logic idx_ok(input logic [4:0] idx);
    return 32'(idx) < NREGS;
  endfunction

  function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  // alt is funct7[5]/instr[30]; it only means SUB for register-register ops.
  function automatic logic [3:0] alu_f3(input logic [2:0] f3, input logic alt,
                                        input logic sub_ok);
    case (f3)
      3'b000:  return (alt && sub_ok) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // ---------------- register file ----------------
  logic [XLEN-1:0] rf_q [NREGS];
  logic [XLEN-1:0] rf_d [NREGS];

  always_comb begin
    rf_d = rf_q;
    if (we_w && rd_w != 5'd0 && idx_ok(rd_w)) rf_d[rd_w[RA-1:0]] = wd_w;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  // Write-first: a same-cycle write to the read index wins over the array.
  function automatic logic [XLEN-1:0] rf_read(input logic [4:0] idx);
    if (idx == 5'd0 || !idx_ok(idx)) return '0;
    if (we_w && rd_w == idx) return wd_w;
    return rf_q[idx[RA-1:0]];
  endfunction

  assign a0_d = rf_q[10];

  // ---------------- decode ----------------
  e_bundle_t dec, e_q, e_d;
  logic        use_rs1, use_rs2, use_rd, legal_op, hazard;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  always_comb begin
    imm_i = {{20{instr_d[31]}}, instr_d[31:20]};
    imm_s = {{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
    imm_b = {{19{instr_d[31]}}, instr_d[31], instr_d[7], instr_d[30:25],
             instr_d[11:8], 1'b0};
    imm_u = {instr_d[31:12], 12'b0};
    imm_j = {{11{instr_d[31]}}, instr_d[31], instr_d[19:12], instr_d[20],
             instr_d[30:21], 1'b0};

    dec         = '0;
    dec.valid   = valid_d;
    dec.funct3  = instr_d[14:12];
    dec.rs1     = instr_d[19:15];
    dec.rs2     = instr_d[24:20];
    dec.rd      = instr_d[11:7];
    dec.rd1     = rf_read(instr_d[19:15]);
    dec.rd2     = rf_read(instr_d[24:20]);
    dec.pc      = pc_d;
    dec.pcplus4 = pc_d + XLEN'(4);
    dec.aluctrl = ALU_ADD;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    use_rd   = 1'b0;
    legal_op = 1'b1;

    case (instr_d[6:0])
      OP_R: begin
        dec.regwrite = 1'b1;
        dec.aluctrl  = alu_f3(instr_d[14:12], instr_d[30], 1'b1);
        use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
      end
      OP_I: begin
        dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.imm = sext(imm_i);
        dec.aluctrl  = alu_f3(instr_d[14:12], instr_d[30], 1'b0);
        use_rs1 = 1'b1; use_rd = 1'b1;
      end
      OP_LD: begin
        dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.resultsrc = 2'b01;
        dec.imm = sext(imm_i);
        use_rs1 = 1'b1; use_rd = 1'b1;
      end
      OP_ST: begin
        dec.memwrite = 1'b1; dec.alusrc = 1'b1; dec.imm = sext(imm_s);
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OP_BR: begin
        dec.branch = 1'b1; dec.aluctrl = ALU_SUB; dec.imm = sext(imm_b);
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OP_JAL: begin
        dec.regwrite = 1'b1; dec.jump = 1'b1; dec.resultsrc = 2'b10;
        dec.imm = sext(imm_j);
        use_rd = 1'b1;
      end
      OP_JALR: begin
        dec.regwrite = 1'b1; dec.jalr = 1'b1; dec.resultsrc = 2'b10;
        dec.alusrc = 1'b1; dec.imm = sext(imm_i);
        use_rs1 = 1'b1; use_rd = 1'b1;
      end
      OP_LUI: begin
        dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.aluctrl = ALU_PASSB;
        dec.imm = sext(imm_u);
        use_rd = 1'b1;
      end
      OP_AUIPC: begin
        dec.regwrite = 1'b1; dec.auipc = 1'b1; dec.alusrc = 1'b1;
        dec.imm = sext(imm_u);
        use_rd = 1'b1;
      end
      default: legal_op = 1'b0;
    endcase

    // Illegal ops keep valid but must have no architectural side effects;
    // resultsrc is cleared too so an illegal "load" never raises a hazard.
    if (!legal_op || (use_rs1 && !idx_ok(dec.rs1)) ||
        (use_rs2 && !idx_ok(dec.rs2)) || (use_rd && !idx_ok(dec.rd))) begin
      dec.illegal   = 1'b1;
      dec.regwrite  = 1'b0;
      dec.memwrite  = 1'b0;
      dec.branch    = 1'b0;
      dec.jump      = 1'b0;
      dec.jalr      = 1'b0;
      dec.auipc     = 1'b0;
      dec.resultsrc = 2'b00;
    end

    hazard = valid_d && e_q.valid && e_q.resultsrc == 2'b01 && e_q.rd != 5'd0 &&
             ((use_rs1 && dec.rs1 == e_q.rd) || (use_rs2 && dec.rs2 == e_q.rd));

    if (flush_e)     e_d = '0;
    else if (hold_e) e_d = e_q;
    else if (hazard) e_d = '0;
    else             e_d = dec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) e_q <= '0;
    else        e_q <= e_d;
  end

  // Gated with rst_n so fetch never sees a stall while held in reset.
  assign stall_d = rst_n & (hazard | hold_e) & ~flush_e;

  assign valid_e     = e_q.valid;
  assign illegal_e   = e_q.illegal;
  assign regwrite_e  = e_q.regwrite;
  assign memwrite_e  = e_q.memwrite;
  assign alusrc_e    = e_q.alusrc;
  assign branch_e    = e_q.branch;
  assign jump_e      = e_q.jump;
  assign jalr_e      = e_q.jalr;
  assign auipc_e     = e_q.auipc;
  assign resultsrc_e = e_q.resultsrc;
  assign aluctrl_e   = e_q.aluctrl;
  assign funct3_e    = e_q.funct3;
  assign imm_e       = e_q.imm;
  assign rd1_e       = e_q.rd1;
  assign rd2_e       = e_q.rd2;
  assign pc_e        = e_q.pc;
  assign pcplus4_e   = e_q.pcplus4;
  assign rs1_e       = e_q.rs1;
  assign rs2_e       = e_q.rs2;
  assign rd_e        = e_q.rd;
endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe: directed + random stimulus for decode_pipe, checked against
// a per-instruction reference model (register array + expected E record).
module tb_decode_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid_d = 1'b0;
  logic [31:0] instr_d = '0, pc_d = '0, wd_w = '0;
  logic        we_w = 1'b0, flush_e = 1'b0, hold_e = 1'b0;
  logic [4:0]  rd_w = '0;

  logic        stall_d, valid_e, illegal_e, regwrite_e, memwrite_e, alusrc_e;
  logic        branch_e, jump_e, jalr_e, auipc_e;
  logic [1:0]  resultsrc_e;
  logic [3:0]  aluctrl_e;
  logic [2:0]  funct3_e;
  logic [31:0] a0_d, imm_e, rd1_e, rd2_e, pc_e, pcplus4_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;

  logic        h_stall_d, h_valid_e, h_illegal_e, h_regwrite_e, h_memwrite_e;
  logic        h_alusrc_e, h_branch_e, h_jump_e, h_jalr_e, h_auipc_e;
  logic [1:0]  h_resultsrc_e;
  logic [3:0]  h_aluctrl_e;
  logic [2:0]  h_funct3_e;
  logic [31:0] h_a0_d, h_imm_e, h_rd1_e, h_rd2_e, h_pc_e, h_pcplus4_e;
  logic [4:0]  h_rs1_e, h_rs2_e, h_rd_e;

  decode_pipe #(.XLEN(32), .NREGS(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .valid_d(valid_d), .instr_d(instr_d), .pc_d(pc_d),
    .we_w(we_w), .rd_w(rd_w), .wd_w(wd_w), .flush_e(flush_e), .hold_e(hold_e),
    .stall_d(stall_d), .a0_d(a0_d), .valid_e(valid_e), .illegal_e(illegal_e),
    .regwrite_e(regwrite_e), .memwrite_e(memwrite_e), .alusrc_e(alusrc_e),
    .branch_e(branch_e), .jump_e(jump_e), .jalr_e(jalr_e), .auipc_e(auipc_e),
    .resultsrc_e(resultsrc_e), .aluctrl_e(aluctrl_e), .funct3_e(funct3_e),
    .imm_e(imm_e), .rd1_e(rd1_e), .rd2_e(rd2_e), .pc_e(pc_e),
    .pcplus4_e(pcplus4_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e));

  decode_pipe #(.XLEN(32), .NREGS(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .valid_d(valid_d), .instr_d(instr_d), .pc_d(pc_d),
    .we_w(we_w), .rd_w(rd_w), .wd_w(wd_w), .flush_e(flush_e), .hold_e(hold_e),
    .stall_d(h_stall_d), .a0_d(h_a0_d), .valid_e(h_valid_e),
    .illegal_e(h_illegal_e), .regwrite_e(h_regwrite_e),
    .memwrite_e(h_memwrite_e), .alusrc_e(h_alusrc_e), .branch_e(h_branch_e),
    .jump_e(h_jump_e), .jalr_e(h_jalr_e), .auipc_e(h_auipc_e),
    .resultsrc_e(h_resultsrc_e), .aluctrl_e(h_aluctrl_e),
    .funct3_e(h_funct3_e), .imm_e(h_imm_e), .rd1_e(h_rd1_e), .rd2_e(h_rd2_e),
    .pc_e(h_pc_e), .pcplus4_e(h_pcplus4_e), .rs1_e(h_rs1_e), .rs2_e(h_rs2_e),
    .rd_e(h_rd_e));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // kind: 0 bubble, 1 legal valid, 2 illegal valid, 3 empty slot (valid_d=0)
  typedef struct {
    int          kind;
    logic        load, u1, u2, c_imm, c_alusrc, c_alu;
    logic        regwrite, memwrite, alusrc, branch, jump, jalr, auipc;
    logic [1:0]  rsrc;
    logic [3:0]  alu;
    logic [2:0]  f3;
    logic [31:0] imm, rd1, rd2, pc, pcp4;
    logic [4:0]  rs1, rs2, rd;
  } exp_t;

  logic [31:0] mregs [32];
  exp_t        me;
  logic        mstall = 1'b0;

  function automatic logic [31:0] mread(input logic [4:0] idx, input logic we,
                                        input logic [4:0] rw, input logic [31:0] wd);
    if (idx == 0) return 32'd0;
    if (we && rw == idx) return wd;
    return mregs[idx];
  endfunction

  function automatic logic [3:0] m_alu(input logic [2:0] f3, input logic b30, input logic is_r);
    logic [3:0] a;
    case (f3)
      3'd0: a = (is_r && b30) ? 4'd1 : 4'd0;
      3'd1: a = 4'd2;
      3'd2: a = 4'd3;
      3'd3: a = 4'd4;
      3'd4: a = 4'd5;
      3'd5: a = b30 ? 4'd7 : 4'd6;
      3'd6: a = 4'd8;
      default: a = 4'd9;
    endcase
    return a;
  endfunction

  function automatic exp_t mdecode(input logic [31:0] ins);
    exp_t x;
    logic [31:0] sgn, iI, iS, iB, iU, iJ;
    x = '{default: '0};
    sgn = {32{ins[31]}};
    iI = 32'($signed(ins) >>> 20);
    iS = ((32'($signed(ins) >>> 25)) << 5) | 32'(ins[11:7]);
    iB = (sgn << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
    iU = ins & 32'hFFFF_F000;
    iJ = (sgn << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
    x.kind = 1; x.c_alusrc = 1; x.c_alu = 1; x.c_imm = 1;
    case (ins[6:0])
      7'h33: begin x.regwrite = 1; x.alu = m_alu(ins[14:12], ins[30], 1); x.c_imm = 0; x.u1 = 1; x.u2 = 1; end
      7'h13: begin x.regwrite = 1; x.alusrc = 1; x.alu = m_alu(ins[14:12], ins[30], 0); x.imm = iI; x.u1 = 1; end
      7'h03: begin x.regwrite = 1; x.alusrc = 1; x.rsrc = 1; x.imm = iI; x.u1 = 1; x.load = 1; end
      7'h23: begin x.memwrite = 1; x.alusrc = 1; x.imm = iS; x.u1 = 1; x.u2 = 1; end
      7'h63: begin x.branch = 1; x.alu = 4'd1; x.imm = iB; x.u1 = 1; x.u2 = 1; end
      7'h6F: begin x.regwrite = 1; x.jump = 1; x.rsrc = 2; x.imm = iJ; x.c_alusrc = 0; x.c_alu = 0; end
      7'h67: begin x.regwrite = 1; x.jalr = 1; x.rsrc = 2; x.alusrc = 1; x.imm = iI; x.u1 = 1; end
      7'h37: begin x.regwrite = 1; x.alusrc = 1; x.alu = 4'd10; x.imm = iU; end
      7'h17: begin x.regwrite = 1; x.auipc = 1; x.alusrc = 1; x.imm = iU; end
      default: x.kind = 2;
    endcase
    x.f3 = ins[14:12]; x.rs1 = ins[19:15]; x.rs2 = ins[24:20]; x.rd = ins[11:7];
    return x;
  endfunction

  task automatic check_e();
    chk("valid_e", valid_e, (me.kind == 1 || me.kind == 2));
    if (me.kind == 0 || me.kind == 2) begin
      chk("illegal_e", illegal_e, (me.kind == 2));
      chk("regwrite_e", regwrite_e, 0);
      chk("memwrite_e", memwrite_e, 0);
      chk("branch_e", branch_e, 0);
      chk("jump_e", jump_e, 0);
      if (me.kind == 0) chk("jalr_e", jalr_e, 0);
    end else if (me.kind == 1) begin
      chk("illegal_e", illegal_e, 0);
      chk("regwrite_e", regwrite_e, me.regwrite);
      chk("memwrite_e", memwrite_e, me.memwrite);
      chk("branch_e", branch_e, me.branch);
      chk("jump_e", jump_e, me.jump);
      chk("jalr_e", jalr_e, me.jalr);
      chk("auipc_e", auipc_e, me.auipc);
      chk("resultsrc_e", resultsrc_e, me.rsrc);
      if (me.c_alusrc) chk("alusrc_e", alusrc_e, me.alusrc);
      if (me.c_alu) chk("aluctrl_e", aluctrl_e, me.alu);
      if (me.c_imm) chk("imm_e", imm_e, me.imm);
      chk("funct3_e", funct3_e, me.f3);
      chk("rd1_e", rd1_e, me.rd1);
      chk("rd2_e", rd2_e, me.rd2);
      chk("pc_e", pc_e, me.pc);
      chk("pcplus4_e", pcplus4_e, me.pcp4);
      chk("rs1_e", rs1_e, me.rs1);
      chk("rs2_e", rs2_e, me.rs2);
      chk("rd_e", rd_e, me.rd);
    end
  endtask

  // One clock of stimulus; entered and left 1 time unit after a rising edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic we, input logic [4:0] rw, input logic [31:0] wd,
                      input logic fl, input logic ho);
    exp_t dn, nxt;
    logic haz;
    valid_d = v; instr_d = ins; pc_d = pc; we_w = we; rd_w = rw; wd_w = wd;
    flush_e = fl; hold_e = ho;
    @(negedge clk);
    dn = mdecode(ins);
    dn.rd1 = mread(ins[19:15], we, rw, wd);
    dn.rd2 = mread(ins[24:20], we, rw, wd);
    dn.pc = pc; dn.pcp4 = pc + 32'd4;
    haz = v && me.kind == 1 && me.load && me.rd != 0 &&
          ((dn.u1 && dn.rs1 == me.rd) || (dn.u2 && dn.rs2 == me.rd));
    mstall = (haz || ho) && !fl;
    chk("stall_d", stall_d, mstall);
    chk("a0_d", a0_d, mregs[10]);
    nxt = dn;
    if (!v) nxt.kind = 3;
    if (fl || (!ho && haz)) nxt.kind = 0;
    else if (ho) nxt = me;
    @(posedge clk);
    if (we && rw != 0) mregs[rw] = wd;
    me = nxt;
    #1 check_e();
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    me = '{default: '0};
    mstall = 1'b0;
  endtask

  logic        rv;
  logic [31:0] rins, rpc;

  initial begin
    model_reset();
    hold_e = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid_e", valid_e, 0);
    chk("rst_regwrite_e", regwrite_e, 0);
    chk("rst_pc_e", pc_e, 0);
    chk("rst_stall_d", stall_d, 0);
    chk("rst_a0_d", a0_d, 0);
    @(posedge clk); @(posedge clk); #1;
    hold_e = 1'b0;
    rst_n = 1'b1;

    // addi x1,x0,5
    step(1, 32'h0050_0093, 32'h100, 0, 0, 0, 0, 0);
    chk("addi_imm", imm_e, 5);
    chk("addi_rd", rd_e, 1);
    chk("addi_alusrc", alusrc_e, 1);
    chk("addi_rd1", rd1_e, 0);
    // seed x1 then load-use
    step(0, 32'h0, 32'h104, 1, 1, 32'h40, 0, 0);
    step(1, 32'h0000_A103, 32'h108, 0, 0, 0, 0, 0);
    step(1, 32'h0021_01B3, 32'h10C, 0, 0, 0, 0, 0);
    chk("ldu_bubble", valid_e, 0);
    step(1, 32'h0021_01B3, 32'h10C, 0, 0, 0, 0, 0);
    chk("ldu_issue_valid", valid_e, 1);
    chk("ldu_issue_rs1", rs1_e, 2);
    chk("ldu_issue_rs2", rs2_e, 2);
    // write-first bypass and x0
    step(1, 32'h0002_8313, 32'h110, 1, 5, 32'hDEAD_BEEF, 0, 0);
    chk("bypass_rd1", rd1_e, 32'hDEAD_BEEF);
    step(1, 32'h0000_0313, 32'h114, 1, 0, 32'h1234, 0, 0);
    chk("x0_rd1", rd1_e, 0);
    step(0, 32'h0, 32'h118, 1, 10, 32'hA5A5, 0, 0);
    step(0, 32'h0, 32'h11C, 0, 0, 0, 0, 0);
    chk("a0_live", a0_d, 32'hA5A5);
    // branch, then flushed branch
    step(1, 32'hFE00_0CE3, 32'h120, 0, 0, 0, 0, 0);
    chk("beq_imm", imm_e, 32'hFFFF_FFF8);
    chk("beq_alu", aluctrl_e, 1);
    step(1, 32'hFE00_0CE3, 32'h120, 0, 0, 0, 1, 0);
    chk("flush_branch", branch_e, 0);
    // hold with new instructions, then reset mid-hold
    step(1, 32'h0050_0093, 32'h124, 0, 0, 0, 0, 0);
    step(1, 32'h0021_01B3, 32'h128, 0, 0, 0, 0, 1);
    step(1, 32'hFE00_0CE3, 32'h12C, 0, 0, 0, 0, 1);
    step(1, 32'h0000_A103, 32'h130, 1, 3, 32'h77, 0, 1);
    chk("hold_imm", imm_e, 5);
    chk("hold_pc", pc_e, 32'h124);
    valid_d = 1; instr_d = 32'h0000_0313; hold_e = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", valid_e, 0);
    chk("mid_rst_imm", imm_e, 0);
    chk("mid_rst_pc", pc_e, 0);
    chk("mid_rst_stall", stall_d, 0);
    chk("mid_rst_a0", a0_d, 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1; hold_e = 1'b0;
    // RV32E instance: out-of-range index and bad opcode
    step(1, 32'h0050_0093, 32'h200, 0, 0, 0, 0, 0);
    step(1, 32'h0010_88B3, 32'h204, 0, 0, 0, 0, 0);
    chk("e16_illegal", h_illegal_e, 1);
    chk("e16_regwrite", h_regwrite_e, 0);
    chk("e16_valid", h_valid_e, 1);
    step(1, 32'h0000_007F, 32'h208, 0, 0, 0, 0, 0);
    chk("e16_badop", h_illegal_e, 1);
    chk("e32_badop", illegal_e, 1);
    // pc wrap
    step(1, 32'h0000_0097, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
    chk("pc_wrap", pcplus4_e, 0);

    // random traffic; fetch holds its instruction while stalled
    rv = 0; rins = 0; rpc = 0;
    for (int n = 0; n < 500; n++) begin
      if (!mstall) begin
        int k;
        logic [6:0] op;
        k = $urandom_range(0, 9);
        case (k)
          0: op = 7'h33; 1: op = 7'h13; 2: op = 7'h03; 3: op = 7'h23;
          4: op = 7'h63; 5: op = 7'h6F; 6: op = 7'h67; 7: op = 7'h37;
          8: op = 7'h17; default: op = ($urandom_range(0, 1) == 0) ? 7'h7F : 7'h00;
        endcase
        rins = $urandom;
        rins[6:0] = op;
        rins[11:7]  = 5'($urandom_range(0, 7));
        rins[19:15] = 5'($urandom_range(0, 7));
        rins[24:20] = 5'($urandom_range(0, 7));
        rv  = ($urandom_range(0, 99) < 85);
        rpc = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      end
      step(rv, rins, rpc, ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)),
           $urandom, ($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 12));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/decode_pipe.md
# decode_pipe

Parametrised decode stage with an owned register file and a registered D/E pipeline boundary. Decodes RV32I instructions into control signals, reads operands with write-first bypass, builds sign-extended immediates and detects load-use hazards. Emits a stall to fetch and inserts bubbles. It sits between the fetch stage and the execute stage, and the writeback stage drives its register-file write port.

## Interface
- XLEN, 32: datapath width, at least 32; immediates are sign-extended to XLEN.
- NREGS, 32: architectural register count, 32 or 16 (RV32E); RA = log2(NREGS).
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- valid_d  in  1  instr_d/pc_d hold a real instruction.
- instr_d  in  32  instruction word.
- pc_d  in  XLEN  instruction address.
- we_w, rd_w[4:0], wd_w[XLEN]  in  register-file write port from writeback.
- flush_e  in  1  kill the instruction entering E (branch or jump taken).
- hold_e  in  1  downstream stall; the E register must not change.
- stall_d  out  1  fetch must hold pc_d/instr_d this cycle.
- a0_d  out  XLEN  live contents of x10, unregistered.
- valid_e, illegal_e, regwrite_e, memwrite_e, alusrc_e, branch_e, jump_e, jalr_e, auipc_e  out  1 each  registered control.
- resultsrc_e  out  2  00 ALU, 01 memory, 10 pc+4.
- aluctrl_e  out  4  0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT, 0100 SLTU, 0101 XOR, 0110 SRL, 0111 SRA, 1000 OR, 1001 AND, 1010 PASSB.
- funct3_e  out  3  funct3 field, passed through for branch and load/store width.
- imm_e, rd1_e, rd2_e, pc_e, pcplus4_e  out  XLEN  registered operands.
- rs1_e, rs2_e, rd_e  out  5  register indices for forwarding.

## Operation
- Opcodes and their control:
  - 0110011 (R-type): ALU op from funct3 and funct7[5].
  - 0010011 (I-type ALU): ALU op from funct3; instr[30] selects SRA for shifts.
  - 0000011 (load): resultsrc 01, ADD.
  - 0100011 (store): memwrite, ADD.
  - 1100011 (branch): branch_e, SUB.
  - 1101111 (JAL): jump_e, resultsrc 10.
  - 1100111 (JALR): jalr_e, resultsrc 10, ADD.
  - 0110111 (LUI): PASSB.
  - 0010111 (AUIPC): auipc_e, ADD.
- Immediate formats: I, S, B, U and J, each sign-extended to XLEN. U-type places instr[31:12] in bits 31:12 with zeros below.
- Illegal instructions:
  - Any other opcode, or any used register index of NREGS or more, sets illegal_e=1.
  - An illegal instruction has valid_e=1 and regwrite, memwrite, branch and jump all 0.
- Register file:
  - NREGS x XLEN.
  - x0 always reads 0.
  - A write happens on the clock edge when we_w=1 and rd_w!=0.
  - Reads are combinational.
  - Bypass: when we_w=1 and rd_w equals the read index (index not 0), the read returns wd_w in the same cycle.
- Load-use hazard:
  - Condition: valid_d, valid_e, resultsrc_e=01 and rd_e!=0, and rd_e matches a source the D instruction actually uses.
  - Sources used per format: rs1 and rs2 for R, S and B; rs1 only for I, load and JALR; none for U and J.
- Priority for loading the E register each cycle:
  1. Reset: all zero.
  2. flush_e: bubble.
  3. hold_e: keep the current contents.
  4. Hazard: bubble.
  5. Otherwise: load the decoded D bundle; valid_e = valid_d.
- A bubble sets valid_e, illegal_e, regwrite_e, memwrite_e, branch_e, jump_e and jalr_e to 0. The data fields are don't-care.
- stall_d = (hazard | hold_e) & ~flush_e.
- pcplus4_e = pc_d + 4, modulo 2^XLEN.

## Timing
- Decode to E output: latency 1 cycle.
- stall_d and a0_d are combinational in the current cycle.
- A load-use hazard costs exactly one bubble. The next cycle the load has left E and the dependent instruction issues.
- Reset is asynchronous:
  - Asserting rst_n clears all E outputs and every register to 0 immediately, including mid-stall.
  - stall_d is 0 while in reset.
- Release is synchronous to the first clk edge after rst_n rises.
- flush_e and a hazard in the same cycle: bubble, stall_d=0.
- hold_e and a hazard in the same cycle: E holds, stall_d=1.
- A register-file write during hold_e still commits.

## Test plan
- addi x1,x0,5 (0x00500093), valid_d=1 -> next edge: valid_e=1, regwrite_e=1, alusrc_e=1, aluctrl_e=0000, imm_e=5, rd_e=1, rd1_e=0.
- lw x2,0(x1) (0x0000A103), then add x3,x2,x2 (0x002101B3) -> stall_d=1 for one cycle, then valid_e=0 bubble, then add in E with rs1_e=rs2_e=2.
- we_w=1, rd_w=5, wd_w=0xDEADBEEF while D reads rs1=5 -> rd1_e=0xDEADBEEF. Writing x0 with 0x1234 -> x0 still reads 0.
- beq x0,x0,-8 (0xFE000CE3) -> branch_e=1, aluctrl_e=0001, imm_e=0xFFFFFFF8. The same instruction with flush_e=1 -> valid_e=0, branch_e=0.
- hold_e=1 for 3 cycles with new instructions presented -> E outputs unchanged, stall_d=1. Assert rst_n=0 mid-hold -> all outputs 0 immediately.
- NREGS=16: add x17,x1,x1 -> illegal_e=1, regwrite_e=0. Opcode 0x7F -> illegal_e=1.
